tribus_arbiter: RTL and testbench

Round-robin arbiter that shares one tri-state bus among N requesters and drives each requester's output enable (the `cond` of its `assign bus = cond ? data : 1'bz`). It guarantees at most one enabled driver per cycle. It inserts a configurable all-released turnaround gap between owners so the net floats to z rather than contending. It bounds each tenure with a hold limit that applies only when another requester is waiting. It sits beside the bus net; requesters never gate their drivers themselves.

---
 rtl/tribus_pkg.sv | 18 +
 rtl/rr_pick.sv | 28 ++
 rtl/tribus_arbiter.sv | 136 +++++++++++++
 tb/tb_tribus_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM encoding and width helpers.
package tribus_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StTurn  = 2'd2;

  // Bits needed to index n requesters (n >= 2).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold any count in 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping at N-1 -> 0.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] winner
);

  logic [W-1:0] cand;

  // Scan last+1, last+2, ... last+N (mod N); the first set request wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = W'((32'(last) + k) % N);
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner of a shared tri-state bus: one-hot-or-zero driver enables, a forced
// all-released turnaround between owners, and a hold limit applied only under contention.
module tribus_arbiter
  import tribus_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned TA       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            gnt,
  output logic [idx_width(N)-1:0] owner,
  output logic                    busy,
  output logic                    preempt
);

  localparam int unsigned W  = idx_width(N);
  localparam int unsigned HW = cnt_width(MAX_HOLD);
  localparam int unsigned TW = cnt_width(TA);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [TW-1:0] ta_q, ta_d;
  logic [W-1:0]  last_q, last_d;

  logic          pick_any;
  logic [W-1:0]  pick_winner;
  logic          others;
  logic          arbitrate;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Contention and arbitration-point decode.
  always_comb begin
    others    = |(req & ~gnt_q);
    hold_inc  = others ? hold_q + HW'(1) : hold_q;
    arbitrate = (state_q == StIdle) || ((state_q == StTurn) && (ta_q == TW'(TA - 1)));
  end

  // Next-state logic for the FSM, counters and registered outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    ta_d      = ta_q;
    last_d    = last_q;

    if (arbitrate) begin
      if (pick_any) begin
        state_d = StGrant;
        gnt_d   = N'(1) << pick_winner;
        owner_d = pick_winner;
        busy_d  = 1'b1;
        last_d  = pick_winner;
        hold_d  = '0;
      end else begin
        state_d = StIdle;
        gnt_d   = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        StGrant: begin
          // Release takes priority over expiry, so a simultaneous drop never flags preempt.
          if (!req[owner_q] || (others && (hold_inc >= HW'(MAX_HOLD)))) begin
            state_d   = StTurn;
            gnt_d     = '0;
            owner_d   = '0;
            busy_d    = 1'b0;
            hold_d    = '0;
            ta_d      = '0;
            preempt_d = req[owner_q];
          end else begin
            hold_d = hold_inc;
          end
        end
        StTurn: begin
          ta_d = ta_q + TW'(1);
        end
        default: begin
          state_d = StIdle;
          gnt_d   = '0;
          owner_d = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset clears every driver enable without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      ta_q      <= '0;
      last_q    <= W'(N - 1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      ta_q      <= ta_d;
      last_q    <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: directed tables and sequences on a TA=1 instance, randomized
// traffic on a TA=2 instance checked against a tenure-level reference model.
module tb_tribus_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned OW    = $clog2(N);
  localparam int unsigned MH    = 8;
  localparam int unsigned TA_A  = 1;
  localparam int unsigned TA_B  = 2;
  localparam int unsigned BOUND = (N - 1) * (MH + TA_B) + TA_B;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_a, req_b, gnt_a, gnt_b;
  logic [OW-1:0] owner_a, owner_b;
  logic          busy_a, busy_b, preempt_a, preempt_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owner index (-1 = bus released), gap cycles left, contended
  // cycles in the current tenure, last winner, preempt flag for this cycle.
  int m_owner, m_gap, m_cont, m_last;
  bit m_pre;

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         pre;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  tribus_arbiter #(.N(N), .MAX_HOLD(MH), .TA(TA_A)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_a),
    .gnt     (gnt_a),
    .owner   (owner_a),
    .busy    (busy_a),
    .preempt (preempt_a)
  );

  tribus_arbiter #(.N(N), .MAX_HOLD(MH), .TA(TA_B)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_b),
    .gnt     (gnt_b),
    .owner   (owner_b),
    .busy    (busy_b),
    .preempt (preempt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {gnt, owner, busy, preempt} derived from a grant vector.
  function automatic logic [31:0] pack_exp(input logic [N-1:0] g, input logic p);
    logic [OW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) if (g[i]) idx = OW'(i);
    return 32'({g, idx, |g, p});
  endfunction

  function automatic logic [31:0] act_a();
    return 32'({gnt_a, owner_a, busy_a, preempt_a});
  endfunction

  function automatic logic [31:0] act_b();
    return 32'({gnt_b, owner_b, busy_b, preempt_b});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 0;
    m_cont  = 0;
    m_last  = N - 1;
    m_pre   = 1'b0;
  endtask

  // One clock edge of the bus policy, applied to the request vector sampled on that edge.
  task automatic model_step(input logic [N-1:0] r);
    bit other;
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      other = (r & ~(N'(1) << m_owner)) != '0;
      if (!r[m_owner]) begin
        m_owner = -1;
        m_gap   = TA_B;
      end else if (other && (m_cont + 1 >= int'(MH))) begin
        m_owner = -1;
        m_gap   = TA_B;
        m_pre   = 1'b1;
      end else if (other) begin
        m_cont++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (r[c]) begin
          m_owner = c;
          m_last  = c;
          m_cont  = 0;
          break;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] model_gnt();
    return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
  endfunction

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] prev_g;
    int           zrun;
    bit           seen;
    int           wt[N];

    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    #2;
    chk("reset_a", act_a(), pack_exp('0, 1'b0));
    chk("reset_b", act_b(), pack_exp('0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Lone requester: granted next edge, holds indefinitely, no preempt.
    req_a = 4'b0001;
    for (int c = 0; c < 19; c++) begin
      tick();
      chk("single_hold", act_a(), pack_exp(4'b0001, 1'b0));
    end
    req_a = 4'b0000;
    tick();
    chk("single_release", act_a(), pack_exp('0, 1'b0));
    tick();
    chk("single_idle", act_a(), pack_exp('0, 1'b0));

    // Full contention: 8-cycle tenures, one-cycle gap carrying the preempt pulse.
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < int'(MH); c++) begin
        tick();
        chk("rotate_tenure", act_a(), pack_exp(4'b0001 << (k % N), 1'b0));
      end
      tick();
      chk("rotate_preempt", act_a(), pack_exp('0, 1'b1));
    end

    // Voluntary release to a pending requester, then release exactly at hold expiry.
    tbl[0]  = '{req: 4'b0100, gnt: 4'b0100, pre: 1'b0};
    tbl[1]  = '{req: 4'b0101, gnt: 4'b0100, pre: 1'b0};
    tbl[2]  = '{req: 4'b0101, gnt: 4'b0100, pre: 1'b0};
    tbl[3]  = '{req: 4'b0001, gnt: 4'b0000, pre: 1'b0};
    tbl[4]  = '{req: 4'b0001, gnt: 4'b0001, pre: 1'b0};
    tbl[5]  = '{req: 4'b0001, gnt: 4'b0001, pre: 1'b0};
    for (int i = 6; i <= 12; i++) tbl[i] = '{req: 4'b0011, gnt: 4'b0001, pre: 1'b0};
    tbl[13] = '{req: 4'b0010, gnt: 4'b0000, pre: 1'b0};
    tbl[14] = '{req: 4'b0010, gnt: 4'b0010, pre: 1'b0};
    tbl[15] = '{req: 4'b0010, gnt: 4'b0010, pre: 1'b0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req_a = tbl[i].req;
      tick();
      chk($sformatf("table_row%0d", i), act_a(), pack_exp(tbl[i].gnt, tbl[i].pre));
    end

    // Reset in the middle of a tenure drops the enable without a clock edge.
    do_reset();
    req_a = 4'b0100;
    tick();
    chk("midreset_grant", act_a(), pack_exp(4'b0100, 1'b0));
    req_a = 4'b1111;
    tick();
    chk("midreset_hold", act_a(), pack_exp(4'b0100, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_async", act_a(), pack_exp('0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    req_a = 4'b1111;
    rst_n = 1'b1;
    tick();
    chk("midreset_first", act_a(), pack_exp(4'b0001, 1'b0));

    // Randomized traffic against the reference model plus bus-safety invariants.
    do_reset();
    model_reset();
    prev_g = '0;
    zrun   = 0;
    seen   = 1'b0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) req_b[i] = ~req_b[i];
      if ($urandom_range(0, 99) == 0) req_b = '1;
      r = req_b;
      tick();
      model_step(r);
      chk("rand_model", act_b(), pack_exp(model_gnt(), m_pre));
      chk("rand_onehot", 32'($countones(gnt_b) <= 1), 32'd1);
      if (gnt_b == '0) begin
        zrun++;
      end else begin
        if (prev_g == '0 && seen) chk("rand_gap", 32'(zrun >= int'(TA_B)), 32'd1);
        if (prev_g != '0) chk("rand_no_direct_handover", 32'(gnt_b), 32'(prev_g));
        zrun = 0;
        seen = 1'b1;
      end
      prev_g = gnt_b;
      for (int i = 0; i < N; i++) begin
        if (r[i] && !gnt_b[i]) begin
          wt[i]++;
          chk($sformatf("rand_wait%0d", i), 32'(wt[i] <= int'(BOUND)), 32'd1);
        end else begin
          wt[i] = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
